// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register file: word offsets, CAPS field
// positions, the unmapped-read value and the scratch byte-lane merge.
package sysid_pkg;

  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_HI = 4'd3;
  localparam logic [3:0] ADDR_CAPS      = 4'd4;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd5;

  localparam int CAPS_UPTIME_BIT = 0;
  localparam int CAPS_LAT2_BIT   = 1;
  localparam int CAPS_NSCR_LSB   = 8;

  localparam logic [31:0] UNMAPPED_VALUE = 32'h0000_0000;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_if.sv
// Memory-mapped slave bus of the system-ID register file (no waitrequest,
// pipelined reads answered through readdatavalid).
interface sysid_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime.sv
// Free-running 64-bit uptime counter with an upper-word snapshot taken on
// every UPTIME_LO read so LO/HI reads form one coherent value.
module sysid_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        snap_en,
  output logic [31:0] uptime_lo,
  output logic [31:0] uptime_hi
);

  logic [63:0] count_r;
  logic [31:0] snap_r;

  // Counter wraps naturally from all-ones to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 64'h0;
      snap_r  <= 32'h0;
    end else begin
      count_r <= count_r + 64'd1;
      if (snap_en) begin
        snap_r <= count_r[63:32];
      end
    end
  end

  assign uptime_lo = count_r[31:0];
  assign uptime_hi = snap_r;

endmodule

// File: rtl/sysid_regfile.sv
// System-ID register file: RO identity/timestamp/caps words, RW scratch words
// and a pipelined read path. Define SYSID_UPTIME_EN to include the uptime counter.
module sysid_regfile
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'h1122_3344,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'h518E_5C60,
  parameter int          NUM_SCRATCH     = 4,
  parameter int          READ_LATENCY    = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  sysid_if.slave bus
);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS_VALUE =
      ((32'(NUM_SCRATCH) & 32'h0000_000F) << CAPS_NSCR_LSB) |
      (32'(READ_LATENCY == 2) << CAPS_LAT2_BIT) |
      (32'(UPTIME_PRESENT) << CAPS_UPTIME_BIT);

  logic [31:0]             scratch_r [NUM_SCRATCH];
  logic [31:0]             scratch_rd_s;
  logic                    scratch_hit_s;
  logic [31:0]             rd_data_s;
  logic [31:0]             uptime_lo_s;
  logic [31:0]             uptime_hi_s;
  logic [READ_LATENCY-1:0] vld_r;
  logic [31:0]             dat_r [READ_LATENCY];

`ifdef SYSID_UPTIME_EN
  logic snap_en_s;

  assign snap_en_s = bus.read && (bus.address == ADDR_UPTIME_LO);

  sysid_uptime u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .snap_en   (snap_en_s),
    .uptime_lo (uptime_lo_s),
    .uptime_hi (uptime_hi_s)
  );
`else
  assign uptime_lo_s = 32'h0;
  assign uptime_hi_s = 32'h0;
`endif

  // Scratch read as an AND-OR mux over the decoded word matches.
  always_comb begin
    scratch_rd_s  = 32'h0;
    scratch_hit_s = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_rd_s  = scratch_rd_s |
                      (scratch_r[i] & {32{bus.address == (ADDR_SCRATCH0 + 4'(i))}});
      scratch_hit_s = scratch_hit_s | (bus.address == (ADDR_SCRATCH0 + 4'(i)));
    end
  end

  always_comb begin
    rd_data_s = UNMAPPED_VALUE;
    case (bus.address)
      ADDR_ID:        rd_data_s = SYSID_ID;
      ADDR_TIMESTAMP: rd_data_s = SYSID_TIMESTAMP;
      ADDR_UPTIME_LO: rd_data_s = uptime_lo_s;
      ADDR_UPTIME_HI: rd_data_s = uptime_hi_s;
      ADDR_CAPS:      rd_data_s = CAPS_VALUE;
      default:        rd_data_s = scratch_hit_s ? scratch_rd_s : UNMAPPED_VALUE;
    endcase
  end

  // Same-cycle reads sample rd_data_s before this update lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_r[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (bus.write && (bus.address == (ADDR_SCRATCH0 + 4'(i)))) begin
          scratch_r[i] <= byte_merge(scratch_r[i], bus.writedata, bus.byteenable);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_r <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_r[i] <= 32'h0;
      end
    end else begin
      vld_r[0] <= bus.read;
      dat_r[0] <= bus.read ? rd_data_s : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign bus.readdata      = dat_r[READ_LATENCY-1];
  assign bus.readdatavalid = vld_r[READ_LATENCY-1];

endmodule
